// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives a combinational ALU from a valid/ready command channel and returns results on a valid/ready response channel
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid/ready/op/a/b   command channel; cmd_use_acc selects acc as operand A
//   alu_inp1/inp2/opcode     registered operands and opcode to the external ALU
//   alu_out/alu_overflow     ALU result and overflow
//   rsp_valid/ready/data     response channel; rsp_ovf/rsp_err qualify rsp_data
//   acc                      accumulator, updated from accepted error-free responses
//   ovf_count                saturating count of accepted overflowed responses
//   busy                     high outside IDLE
module alu_cmd_sequencer #(
    parameter int WIDTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic                 cmd_use_acc,
    output logic [WIDTH-1:0]     alu_inp1,
    output logic [WIDTH-1:0]     alu_inp2,
    output logic [2:0]           alu_opcode,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic [WIDTH-1:0]     acc,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            ovf_count  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            alu_inp1   <= '0;
            alu_inp2   <= '0;
            alu_opcode <= 3'b111;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    if (cmd_op != 3'b000) begin
                        alu_opcode <= cmd_op;
                        alu_inp1   <= cmd_use_acc ? acc : cmd_a;
                        alu_inp2   <= cmd_b;
                        state      <= EXEC;
                    end else begin
                        // illegal opcode bypasses the ALU; its inputs keep the idle code
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_ovf   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    // only add and subtract report a meaningful overflow
                    rsp_ovf   <= alu_overflow && (alu_opcode == 3'b001 || alu_opcode == 3'b010);
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid  <= 1'b0;
                    acc        <= rsp_err ? acc : rsp_data;
                    ovf_count  <= (rsp_ovf && !(&ovf_count)) ? ovf_count + 1'b1 : ovf_count;
                    alu_opcode <= 3'b111;
                    alu_inp1   <= '0;
                    alu_inp2   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
